// File: rtl/i2c_gain_regfile.sv
// Write-only I2C slave feeding a bank of per-band 8-bit gain registers.
// Optional atomic commit on STOP when GAIN_SHADOW_EN is defined.
module i2c_gain_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  parameter int         NUM_BANDS  = 10,
  parameter logic [7:0] BASE_ADDR  = 8'h01,
  parameter logic [7:0] GAIN_RST   = 8'd16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic [8*NUM_BANDS-1:0] gains,
  output logic                   gain_upd,
  output logic                   busy
);

  localparam int         IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [8:0] NB_LIM = 9'(NUM_BANDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q, ptr_q;
  logic       sda_oe_q, busy_q, upd_q;
  logic [7:0] gain_q [NUM_BANDS];
`ifdef GAIN_SHADOW_EN
  logic [7:0] shadow_q [NUM_BANDS];
  logic       dirty_q;
`endif

  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] shift_d, ptr_d, idx_s;
  logic       in_range_s, addr_match_s;
  logic [IDX_W-1:0] band_s;

  // Two-stage synchronisers plus one edge-history stage for SCL and SDA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Next-value helpers and the register-window decode of the pointer.
  always_comb begin
    shift_d      = {shift_q[6:0], sda_s};
    ptr_d        = ptr_q + 8'd1;
    idx_s        = ptr_q - BASE_ADDR;
    in_range_s   = (ptr_q >= BASE_ADDR) && ({1'b0, idx_s} < NB_LIM);
    band_s       = idx_s[IDX_W-1:0];
    addr_match_s = (shift_q == {SLAVE_ADDR, 1'b0});
  end

  // Protocol FSM, pointer, gain bank and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 8'd0;
      ptr_q    <= 8'd0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) gain_q[k] <= GAIN_RST;
`ifdef GAIN_SHADOW_EN
      for (int k = 0; k < NUM_BANDS; k++) shadow_q[k] <= GAIN_RST;
      dirty_q <= 1'b0;
`endif
    end else begin
      upd_q <= 1'b0;
      if (stop_s) begin
        state_q  <= ST_IDLE;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
`ifdef GAIN_SHADOW_EN
        if (dirty_q) begin
          gain_q <= shadow_q;
          upd_q  <= 1'b1;
        end
        dirty_q <= 1'b0;
`endif
      end else if (start_s) begin
        // Repeated START keeps busy; a partial byte is simply dropped.
        state_q  <= ST_ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
`ifdef GAIN_SHADOW_EN
        shadow_q <= gain_q;
        dirty_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_ADDR, ST_REG, ST_DATA: begin
            if (scl_rise_s && (cnt_q < 4'd8)) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall_s && (cnt_q == 4'd8)) begin
              cnt_q <= 4'd0;
              if (state_q == ST_ADDR) begin
                if (addr_match_s) begin
                  state_q  <= ST_ADDR_ACK;
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                end else begin
                  state_q <= ST_IGNORE;
                  busy_q  <= 1'b0;
                end
              end else if (state_q == ST_REG) begin
                ptr_q    <= shift_q;
                state_q  <= ST_REG_ACK;
                sda_oe_q <= 1'b1;
              end else begin
                state_q  <= ST_DATA_ACK;
                sda_oe_q <= 1'b1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_REG;
            end
          end
          ST_REG_ACK: begin
            if (scl_fall_s) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_DATA;
            end
          end
          ST_DATA_ACK: begin
            if (scl_fall_s) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_DATA;
              ptr_q    <= ptr_d;
              if (in_range_s) begin
`ifdef GAIN_SHADOW_EN
                shadow_q[band_s] <= shift_q;
                dirty_q          <= 1'b1;
`else
                gain_q[band_s] <= shift_q;
                upd_q          <= 1'b1;
`endif
              end
            end
          end
          ST_IDLE, ST_IGNORE: begin
            sda_oe_q <= 1'b0;
          end
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_gains
    assign gains[8*g +: 8] = gain_q[g];
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign gain_upd = upd_q;

endmodule

// File: tb/tb_i2c_gain_regfile.sv
// Directed and randomized I2C write traffic against a band-level reference model.
module tb_i2c_gain_regfile;

  localparam int         NB   = 10;
  localparam logic [7:0] BASE = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic          sda_oe;
  logic [8*NB-1:0] gains;
  logic          gain_upd;
  logic          busy;

  int total = 0;
  int bad = 0;
  int upd_seen = 0;
  int m_upd = 0;
  logic [7:0] m_gain [NB];
  logic [7:0] m_pend [NB];
  logic       m_dirty;

  assign sda_line = sda_m & ~sda_oe;

  i2c_gain_regfile dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .gains(gains), .gain_upd(gain_upd), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (gain_upd === 1'b1) upd_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; ack = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (sda_oe !== 1'b1) ack = 1'b0;
    end
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) m_gain[k] = 8'd16;
    m_dirty = 1'b0;
  endtask

  task automatic model_begin();
    for (int k = 0; k < NB; k++) m_pend[k] = m_gain[k];
    m_dirty = 1'b0;
  endtask

  task automatic model_data(inout logic [7:0] p, input logic [7:0] b);
    int idx;
    idx = int'(p) - int'(BASE);
    if (idx >= 0 && idx < NB) begin
`ifdef GAIN_SHADOW_EN
      m_pend[idx] = b;
      m_dirty = 1'b1;
`else
      m_gain[idx] = b;
      m_upd++;
`endif
    end
    p = p + 8'd1;
  endtask

  task automatic model_stop();
`ifdef GAIN_SHADOW_EN
    if (m_dirty) begin
      for (int k = 0; k < NB; k++) m_gain[k] = m_pend[k];
      m_upd++;
    end
`endif
    m_dirty = 1'b0;
  endtask

  task automatic check_gains(input string tag);
    for (int k = 0; k < NB; k++)
      check($sformatf("%s_band%0d", tag, k), 32'(gains[8*k +: 8]), 32'(m_gain[k]));
    check({tag, "_upd"}, 32'(upd_seen), 32'(m_upd));
  endtask

  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] r, input logic [7:0] d[$]);
    logic ack, exp_ack;
    logic [7:0] p;
    exp_ack = (a == 8'hD4);
    i2c_start();
    model_begin();
    send_byte(a, ack);
    check({tag, "_aack"}, 32'(ack), 32'(exp_ack));
    check({tag, "_busy"}, 32'(busy), 32'(exp_ack));
    send_byte(r, ack);
    check({tag, "_rack"}, 32'(ack), 32'(exp_ack));
    p = r;
    foreach (d[i]) begin
      send_byte(d[i], ack);
      check($sformatf("%s_dack%0d", tag, i), 32'(ack), 32'(exp_ack));
      if (exp_ack) model_data(p, d[i]);
    end
    i2c_stop();
    model_stop();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_gains(tag);
  endtask

  initial begin
    logic [7:0] q[$];
    logic ack, seen;
    logic [7:0] p, r, a;
    int n;

    // 1: reset state
    model_reset();
    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd", 32'(gain_upd), 32'd0);
    check_gains("rst");

    // 2: fill every band with 17
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(8'd17);
    txn("fill", 8'hD4, 8'h01, q);

    // 3: foreign address is ignored
    txn("foreign", 8'hD6, 8'h02, '{8'h99, 8'h98});

    // 4: last band then out of range
    txn("edge", 8'hD4, 8'h0A, '{8'h33, 8'h44, 8'h55});

    // 5: partial byte cut by repeated START
    i2c_start();
    model_begin();
    send_byte(8'hD4, ack); check("rs_aack", 32'(ack), 32'd1);
    send_byte(8'h03, ack); check("rs_rack", 32'(ack), 32'd1);
    p = 8'h03;
    send_byte(8'hAA, ack); check("rs_dack", 32'(ack), 32'd1);
    model_data(p, 8'hAA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check_gains("rs_mid");
    i2c_start();
    model_begin();
    send_byte(8'hD4, ack); check("rs2_aack", 32'(ack), 32'd1);
    send_byte(8'h05, ack); check("rs2_rack", 32'(ack), 32'd1);
    p = 8'h05;
    send_byte(8'h77, ack); check("rs2_dack", 32'(ack), 32'd1);
    model_data(p, 8'h77);
    i2c_stop();
    model_stop();
    check_gains("rs2");

    // 6: reset in the middle of the data byte ACK
    i2c_start();
    send_byte(8'hD4, ack); check("ab_aack", 32'(ack), 32'd1);
    send_byte(8'h02, ack); check("ab_rack", 32'(ack), 32'd1);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    sda_m = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (sda_oe === 1'b1) seen = 1'b1;
    end
    check("ab_ack_drive", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check("ab_sda_rel", 32'(sda_oe), 32'd0);
    model_reset();
    wait_clk(2);
    check("ab_busy", 32'(busy), 32'd0);
    check_gains("ab");
    rst = 1'b0;
    wait_clk(4);
    scl_m = 1'b1; wait_clk(8); scl_m = 1'b0; wait_clk(4);
    send_byte(8'h5A, ack); check("ab_noack", 32'(ack), 32'd0);
    check("ab_busy2", 32'(busy), 32'd0);
    i2c_stop();
    check_gains("ab_after");

    // Randomized transactions, including pointer wrap and rejected addresses
    for (int t = 0; t < 8; t++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 12));
      a = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hD5 : 8'hD6) : 8'hD4;
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      txn($sformatf("rnd%0d", t), a, r, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
